// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin contention; default build is fixed priority (LS wins).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [DATA_W/8-1:0]   ls_be_i,
  input  logic [ADDR_W-1:0]     ls_addr_i,
  input  logic [DATA_W-1:0]     ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_W-1:0]     ls_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t r_state, w_state_nxt;
  logic r_owner;
  logic r_we;
  logic [DATA_W/8-1:0] r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic w_any, w_pick_ls, w_latch;
`ifdef MEM_ARB_RR_EN
  logic r_last_ls;
`endif
  always_comb begin
    w_any = if_req_i | ls_req_i;
`ifdef MEM_ARB_RR_EN
    w_pick_ls = ls_req_i & (~if_req_i | ~r_last_ls);
`else
    w_pick_ls = ls_req_i;
`endif
    w_latch = w_any & ((r_state == IDLE) | ((r_state == RESP) & mem_rvalid_i));
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_any ? REQ : IDLE;
      REQ:     w_state_nxt = mem_gnt_i ? RESP : REQ;
      RESP:    w_state_nxt = mem_rvalid_i ? (w_any ? REQ : IDLE) : RESP;
      default: w_state_nxt = IDLE;
    endcase
    mem_req_o   = r_state == REQ;
    if_gnt_o    = mem_req_o & mem_gnt_i & ~r_owner;
    ls_gnt_o    = mem_req_o & mem_gnt_i & r_owner;
    if_rvalid_o = (r_state == RESP) & mem_rvalid_i & ~r_owner;
    ls_rvalid_o = (r_state == RESP) & mem_rvalid_i & r_owner;
    busy_o      = r_state != IDLE;
  end
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  always_ff @(posedge clk_i)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // fetches are always full-word reads
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_owner <= w_pick_ls;
      r_we    <= w_pick_ls & ls_we_i;
      r_be    <= w_pick_ls ? ls_be_i : '1;
      r_addr  <= w_pick_ls ? ls_addr_i : if_addr_i;
      r_wdata <= w_pick_ls ? ls_wdata_i : '0;
    end
`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk_i)
    if (!rst_ni) r_last_ls <= 1'b0;
    else if (w_latch) r_last_ls <= w_pick_ls;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios checked against a transaction-level model every cycle.
module tb_mem_port_arbiter;
  logic clk = 0;
  logic rst_ni = 0;
  logic if_req_i = 0, ls_req_i = 0, ls_we_i = 0;
  logic [31:0] if_addr_i = 0, ls_addr_i = 0, ls_wdata_i = 0, mem_rdata_i = 0;
  logic [3:0] ls_be_i = 0;
  logic mem_gnt_i = 0, mem_rvalid_i = 0;
  logic if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_req_o, mem_we_o, busy_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  mem_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: at most one transaction record, either waiting for grant or for response
  bit m_valid = 0, m_granted = 0, m_owner_ls = 0, m_last_ls = 0, m_we = 0;
  logic [3:0] m_be = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;

  always @(posedge clk) begin
    bit free, pick;
    if (!rst_ni) begin
      m_valid = 0; m_granted = 0; m_owner_ls = 0; m_last_ls = 0;
      m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
    end else begin
      free = !m_valid || (m_granted && mem_rvalid_i);
      if (m_valid && !m_granted && mem_gnt_i) m_granted = 1;
      if (free) begin
        m_valid = 0;
        if (if_req_i || ls_req_i) begin
`ifdef MEM_ARB_RR_EN
          pick = ls_req_i && (!if_req_i || !m_last_ls);
`else
          pick = ls_req_i;
`endif
          m_valid = 1; m_granted = 0; m_owner_ls = pick; m_last_ls = pick;
          m_we    = pick ? ls_we_i : 1'b0;
          m_be    = pick ? ls_be_i : 4'hF;
          m_addr  = pick ? ls_addr_i : if_addr_i;
          m_wdata = pick ? ls_wdata_i : 32'h0;
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    bit e_req, e_resp;
    e_req  = m_valid && !m_granted;
    e_resp = m_valid && m_granted && mem_rvalid_i;
    check("mem_req", mem_req_o, e_req);
    check("if_gnt", if_gnt_o, e_req && mem_gnt_i && !m_owner_ls);
    check("ls_gnt", ls_gnt_o, e_req && mem_gnt_i && m_owner_ls);
    check("if_rvalid", if_rvalid_o, e_resp && !m_owner_ls);
    check("ls_rvalid", ls_rvalid_o, e_resp && m_owner_ls);
    check("busy", busy_o, m_valid);
    check("mem_we", mem_we_o, m_we);
    check("mem_be", mem_be_o, m_be);
    check("mem_addr", mem_addr_o, m_addr);
    check("mem_wdata", mem_wdata_o, m_wdata);
    check("if_rdata", if_rdata_o, mem_rdata_i);
    check("ls_rdata", ls_rdata_o, mem_rdata_i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_if, n_ls;
    tick(); tick();
    chk_en = 1;
    @(negedge clk);
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_be", mem_be_o, 0);
    check("rst_busy", busy_o, 0);
    rst_ni = 1;
    tick();
    // single fetch
    if_req_i = 1; if_addr_i = 32'h100;
    tick(); mem_gnt_i = 1;
    @(negedge clk);
    check("fetch_gnt", if_gnt_o, 1);
    check("fetch_addr", mem_addr_o, 32'h100);
    check("fetch_we", mem_we_o, 0);
    check("fetch_be", mem_be_o, 4'hF);
    tick(); if_req_i = 0; mem_gnt_i = 0;
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    check("fetch_rvalid", if_rvalid_o, 1);
    check("fetch_rdata", if_rdata_o, 32'hDEADBEEF);
    check("fetch_ls_rvalid", ls_rvalid_o, 0);
    tick(); mem_rvalid_i = 0;
    @(negedge clk);
    check("fetch_idle", busy_o, 0);
    // store
    tick();
    ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'b0011; ls_addr_i = 32'h200; ls_wdata_i = 32'h1234;
    tick(); mem_gnt_i = 1;
    @(negedge clk);
    check("st_gnt", ls_gnt_o, 1);
    check("st_we", mem_we_o, 1);
    check("st_be", mem_be_o, 4'b0011);
    check("st_addr", mem_addr_o, 32'h200);
    check("st_wdata", mem_wdata_o, 32'h1234);
    tick(); ls_req_i = 0; ls_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    @(negedge clk);
    check("st_ack", ls_rvalid_o, 1);
    tick(); mem_rvalid_i = 0;
    // contention over 4 back-to-back transactions
    tick();
    if_req_i = 1; if_addr_i = 32'h140; ls_req_i = 1; ls_addr_i = 32'h240; ls_be_i = 4'hF;
    n_if = 0; n_ls = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); mem_gnt_i = 1; mem_rvalid_i = 0;
      @(negedge clk);
      n_if += int'(if_gnt_o); n_ls += int'(ls_gnt_o);
`ifdef MEM_ARB_RR_EN
      check("rr_order", ls_gnt_o, (k % 2) == 0);
`endif
      tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1000 + k;
      if (k == 3) begin if_req_i = 0; ls_req_i = 0; end
    end
    tick(); mem_rvalid_i = 0;
`ifdef MEM_ARB_RR_EN
    check("cont_ls_cnt", n_ls, 2);
    check("cont_if_cnt", n_if, 2);
`else
    check("cont_ls_cnt", n_ls, 4);
    check("cont_if_cnt", n_if, 0);
`endif
    // stalled memory
    tick();
    if_req_i = 1; if_addr_i = 32'h300;
    for (int k = 0; k < 10; k++) begin
      tick(); mem_gnt_i = 0;
      @(negedge clk);
      check("stall_req", mem_req_o, 1);
      check("stall_addr", mem_addr_o, 32'h300);
      check("stall_gnt", if_gnt_o, 0);
    end
    tick(); mem_gnt_i = 1;
    @(negedge clk);
    check("stall_release", if_gnt_o, 1);
    tick(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    tick(); mem_rvalid_i = 0;
    // back-to-back: load pending when fetch response arrives
    tick();
    if_req_i = 1; if_addr_i = 32'h400;
    tick(); mem_gnt_i = 1;
    tick(); mem_gnt_i = 0; if_req_i = 0; mem_rvalid_i = 1;
    ls_req_i = 1; ls_we_i = 0; ls_be_i = 4'hC; ls_addr_i = 32'h500;
    tick(); mem_rvalid_i = 0; mem_gnt_i = 1;
    @(negedge clk);
    check("b2b_req", mem_req_o, 1);
    check("b2b_addr", mem_addr_o, 32'h500);
    check("b2b_be", mem_be_o, 4'hC);
    check("b2b_gnt", ls_gnt_o, 1);
    tick(); ls_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    tick(); mem_rvalid_i = 0;
    // reset while waiting for response
    tick();
    if_req_i = 1; if_addr_i = 32'h600;
    tick(); mem_gnt_i = 1;
    tick(); mem_gnt_i = 0; if_req_i = 0; rst_ni = 0;
    tick(); rst_ni = 1; mem_rvalid_i = 1;
    @(negedge clk);
    check("rr_busy", busy_o, 0);
    check("rr_addr", mem_addr_o, 0);
    check("rr_if_rvalid", if_rvalid_o, 0);
    check("rr_ls_rvalid", ls_rvalid_o, 0);
    tick(); mem_rvalid_i = 0;
    @(negedge clk);
    check("rr_idle", busy_o, 0);
    tick();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
